// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory that the fetch stage reads.
// A host link streams bytes over a valid/ready handshake. The first four
// bytes are the little-endian word count N. The next 4*N bytes are image
// words, also little-endian. Each word goes to a consecutive
// instruction-memory address starting at BASE_ADDR. The core is held
// (cpu_hold=1) until a complete and valid image has been loaded.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, four more bytes follow the last data word. They carry a
//   checksum C that must equal N XOR all N data words. On a mismatch, err is
//   raised and the core stays held. The data words are still written.
//   When undefined, err reflects only a rejected length.
//
// Parameters:
//   ADDR_W     width of the instruction-memory word address
//   DEPTH      maximum number of words an image may contain
//   BASE_ADDR  word address that receives the first image word
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE)
//   in_data     byte from the host link
//   in_valid    in_data valid this cycle
//   in_ready    loader accepts a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   write word address (holds its last value between writes)
//   imem_wdata  write data
//   cpu_hold    holds the pipeline PC while 1
//   done        high while the loader sits in DONE
//   err         image rejected; sticky until the next start or reset
//   load_count  number of words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [31:0]       LP_DEPTH = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Byte assembly. Only the first three bytes are stored. The fourth byte
  // comes straight from in_data, so a complete word is available in the
  // same cycle as its last handshake.
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;

  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_load_count;
  logic              r_err;

  // The write register is separate from the assembly register. This lets
  // the next word's first byte be accepted during the write cycle.
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic              w_ready;
  logic              w_fire;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic              w_len_bad;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_last_word;
  logic              w_start_ok;
  logic              w_do_write;
  logic              w_len_err;
  logic              w_csum_err;

  // in_ready depends only on the state. It is kept out of the next-state
  // process so the handshake logic has no combinational loop.
  assign w_ready     = (r_state == S_LEN) || (r_state == S_DATA) ||
                       (r_state == S_CSUM);
  assign w_fire      = in_valid & w_ready;
  assign w_word_done = w_fire & (r_byte_idx == 2'd3);
  assign w_word      = {in_data, r_asm};
  assign w_len_bad   = (w_word == 32'd0) || (w_word > LP_DEPTH);
  assign w_count_inc = r_load_count + 1'b1;
  assign w_last_word = (w_count_inc == r_len);
  assign w_start_ok  = start & ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_do_write  = (r_state == S_DATA) & w_word_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. That way no path
  // leaves a value unassigned, and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_len_err    = 1'b0;
    w_csum_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_LEN;
      end

      S_LEN: begin
        if (w_word_done) begin
          if (w_len_bad) begin
            w_len_err    = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        // The last word's write strobe fires in the first cycle after this
        // transition. The write register drives it independently of the state.
        if (w_word_done && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_DONE;
`endif
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_word_done) begin
          w_state_next = S_DONE;
          if (w_word != r_csum) w_csum_err = 1'b1;
        end
      end
`endif

      S_DONE: begin
        if (start) w_state_next = S_LEN;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte assembly, write register, counters, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'd0;
      r_len        <= '0;
      r_load_count <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= 32'd0;
`endif
    end else begin
      r_we <= 1'b0;

      if (w_start_ok) begin
        // A new load begins with a clean byte phase, count and error flag.
        r_byte_idx   <= 2'd0;
        r_load_count <= '0;
        r_err        <= 1'b0;
      end else begin
        if (w_fire) begin
          r_byte_idx <= r_byte_idx + 1'b1;
          case (r_byte_idx)
            2'd0:    r_asm[7:0]   <= in_data;
            2'd1:    r_asm[15:8]  <= in_data;
            2'd2:    r_asm[23:16] <= in_data;
            default: ;
          endcase
        end

        if ((r_state == S_LEN) && w_word_done && !w_len_bad) begin
          r_len <= w_word[ADDR_W:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum <= w_word;
`endif
        end

        if (w_do_write) begin
          r_we         <= 1'b1;
          r_addr       <= LP_BASE + r_load_count[ADDR_W-1:0];
          r_wdata      <= w_word;
          r_load_count <= w_count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum       <= r_csum ^ w_word;
`endif
        end

        if (w_len_err || w_csum_err) r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign cpu_hold   = ~((r_state == S_DONE) & ~r_err);
  assign load_count = r_load_count;

endmodule
